// File: rtl/expr_eval_sched.sv
// rtl/expr_eval_sched.sv - round-robin scheduler sharing one expression evaluator (optional txn_cnt_o via EXPR_SCHED_TXNCNT_EN)
module expr_eval_sched #(
    parameter int NREQ = 4,
    parameter int OPW  = 60,
    parameter int RESW = 90,
    parameter int LAT  = 0,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [NREQ*OPW-1:0]  req_ops_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic [OPW-1:0]       ev_ops_o,
    input  logic [RESW-1:0]      ev_res_i,
    output logic                 rsp_valid_o,
    output logic [IDW-1:0]       rsp_id_o,
    output logic [RESW-1:0]      rsp_data_o,
    input  logic                 rsp_ready_i,
    output logic                 busy_o
`ifdef EXPR_SCHED_TXNCNT_EN
    ,
    output logic [15:0]          txn_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EVAL,
        ST_RESP
    } state_e;

    state_e          state_q;
    logic [IDW-1:0]  last_q;
    logic [2:0]      cnt_q;
    logic [OPW-1:0]  ev_ops_q;
    logic            rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [RESW-1:0] rsp_data_q;

    logic            found_d;
    logic [IDW-1:0]  gnt_idx_d;
    logic [IDW:0]    scan_idx;

    // Round-robin search: first valid requester starting just after the last winner.
    always_comb begin
        found_d   = 1'b0;
        gnt_idx_d = '0;
        scan_idx  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            scan_idx = {1'b0, last_q} + (IDW+1)'(k);
            if (scan_idx >= (IDW+1)'(NREQ)) begin
                scan_idx = scan_idx - (IDW+1)'(NREQ);
            end
            if (!found_d && req_valid_i[scan_idx[IDW-1:0]]) begin
                found_d   = 1'b1;
                gnt_idx_d = scan_idx[IDW-1:0];
            end
        end
    end

    // Grant is offered only while idle, so at most one transaction is ever in flight.
    always_comb begin
        req_ready_o = '0;
        if (state_q == ST_IDLE && found_d) begin
            req_ready_o = NREQ'(1) << gnt_idx_d;
        end
    end

    // Scheduler FSM: accept a request, let the evaluator settle LAT cycles, hold the result until taken.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            last_q      <= IDW'(NREQ-1);
            cnt_q       <= '0;
            ev_ops_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (found_d) begin
                        ev_ops_q <= req_ops_i[gnt_idx_d*OPW +: OPW];
                        rsp_id_q <= gnt_idx_d;
                        last_q   <= gnt_idx_d;
                        cnt_q    <= 3'(LAT);
                        state_q  <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (cnt_q == 3'd0) begin
                        rsp_data_q  <= ev_res_i;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ev_ops_o    = ev_ops_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_data_o  = rsp_data_q;
    assign busy_o      = (state_q != ST_IDLE);

`ifdef EXPR_SCHED_TXNCNT_EN
    logic [15:0] txn_cnt_q;
    logic [15:0] txn_cnt_d;

    // Count accepted responses, sticking at the top value.
    always_comb begin
        txn_cnt_d = txn_cnt_q;
        if (rsp_valid_q && rsp_ready_i && txn_cnt_q != 16'hFFFF) begin
            txn_cnt_d = txn_cnt_q + 16'd1;
        end
    end

    // Transaction counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            txn_cnt_q <= '0;
        end else begin
            txn_cnt_q <= txn_cnt_d;
        end
    end

    assign txn_cnt_o = txn_cnt_q;
`endif

endmodule

// File: doc/expr_eval_sched.md
Name: expr_eval_sched

Overview:
- Round-robin scheduler that shares one combinational expression-evaluator datapath among NREQ requesters.
- Each requester presents a packed operand vector: a0..a5 followed by b0..b5, 60 bits total.
- The block registers the winner's operands onto the evaluator bus and waits a fixed LAT cycles.
- It then captures the result, up to 90 bits, and returns it tagged with the requester ID over a valid/ready response channel.

Parameters:
- NREQ, 4, number of requesters (2..8).
- OPW, 60, packed operand width per requester.
- RESW, 90, evaluator result width.
- LAT, 0, extra settle cycles after operands are driven before the result is sampled (0..7).
- IDW, $clog2(NREQ), response ID width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ops  in  NREQ*OPW  operand vectors; requester i occupies bits [i*OPW +: OPW].
- req_ready  out  NREQ  one-hot grant/accept.
- ev_ops  out  OPW  registered operand bus to the evaluator.
- ev_res  in  RESW  evaluator result (combinational from ev_ops).
- rsp_valid  out  1  result available.
- rsp_id  out  IDW  index of the requester that owns rsp_data.
- rsp_data  out  RESW  captured result.
- rsp_ready  in  1  consumer accepts the response.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - state=IDLE, ev_ops=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has first priority.
  - Settle counter cnt=0.
- FSM states: IDLE, EVAL, RESP. One transaction in flight at a time.
- IDLE:
  - Winner g = first i with req_valid[i], scanning last+1, last+2, ... modulo NREQ.
  - req_ready[g]=1 combinationally; all other req_ready bits 0.
  - req_ready is 0 in every state other than IDLE.
  - On the handshake edge: ev_ops <= req_ops[g], rsp_id <= g, last <= g, cnt <= LAT, state <= EVAL.
  - If no request is valid, state stays IDLE and all registers hold.
- EVAL:
  - If cnt==0: rsp_data <= ev_res, rsp_valid <= 1, state <= RESP.
  - Otherwise cnt <= cnt-1.
- RESP:
  - rsp_valid, rsp_id and rsp_data are held stable until rsp_valid && rsp_ready.
  - On that edge: rsp_valid <= 0, state <= IDLE.
- Timing:
  - Handshake at edge T → ev_ops valid from T+1 → result sampled at edge T+1+LAT → rsp_valid high from T+2+LAT.
  - A new grant is possible no earlier than the cycle after response acceptance.
  - Minimum period is LAT+3 cycles per transaction.
- ev_ops is not cleared between transactions; it keeps the last granted vector.
- Requesters may drop req_valid without a handshake; no state change results.
- Pointer update and fairness:
  - The pointer updates only on a grant.
  - A requester that stays valid is granted within NREQ transactions.
- Width rules: no arithmetic on data. ev_res is captured verbatim at full width.
- Reset mid-operation: returns to IDLE immediately. The in-flight transaction is dropped with no response, and its requester must re-present.
- rsp_ready asserted while rsp_valid=0 is ignored.

Optional Feature:
- EXPR_SCHED_TXNCNT_EN defined:
  - Adds output port txn_cnt [15:0].
  - Reset 0; increments on each response handshake (rsp_valid && rsp_ready).
  - Saturates at 16'hFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release with req_valid=4'b0000 → busy=0, rsp_valid=0, req_ready=0 and ev_ops=0 indefinitely.
- Single request, LAT=0:
  - Stimulus: req_valid=4'b0100, req_ops[2]=60'h0ABC, evaluator model y=~ops zero-extended, rsp_ready=1.
  - Required: req_ready=4'b0100 in the first IDLE cycle; rsp_valid two cycles after the handshake with rsp_id=2 and rsp_data=model(60'h0ABC).
- All four requesters valid continuously, rsp_ready=1 → grant order 0,1,2,3,0,1 with rsp_id matching, one response every 3 cycles.
- Backpressure with LAT=3:
  - Stimulus: rsp_ready held low for 10 cycles after rsp_valid rises.
  - Required: rsp_data and rsp_id stable throughout, req_ready=0 throughout, and the next grant one cycle after rsp_ready rises.
- Async reset mid-transaction:
  - Stimulus: rst_n pulsed low during EVAL.
  - Required: immediate rsp_valid=0 and busy=0; after release, requester 0 wins over 3 when both are valid.
- With EXPR_SCHED_TXNCNT_EN: txn_cnt preloaded via force to 16'hFFFE, then 3 response handshakes → txn_cnt ends at 16'hFFFF.
